// File: rtl/arith_fnd_pkg.sv
// Shared definitions for the arithmetic result display stage.
//   conv_state_t : binary-to-BCD converter states
//   FONT_*       : active-low 7-segment patterns, bit order {dp,g,f,e,d,c,b,a}
//   seg_font()   : digit (0..9) to segment pattern; anything else is blank
package arith_fnd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    LOAD = 2'd2
  } conv_state_t;

  localparam logic [7:0] FONT_0     = 8'hC0;
  localparam logic [7:0] FONT_1     = 8'hF9;
  localparam logic [7:0] FONT_2     = 8'hA4;
  localparam logic [7:0] FONT_3     = 8'hB0;
  localparam logic [7:0] FONT_4     = 8'h99;
  localparam logic [7:0] FONT_5     = 8'h92;
  localparam logic [7:0] FONT_6     = 8'h82;
  localparam logic [7:0] FONT_7     = 8'hF8;
  localparam logic [7:0] FONT_8     = 8'h80;
  localparam logic [7:0] FONT_9     = 8'h90;
  localparam logic [7:0] FONT_BLANK = 8'hFF;

  function automatic logic [7:0] seg_font(input logic [3:0] i_digit);
    logic [7:0] w_font;
    case (i_digit)
      4'd0:    w_font = FONT_0;
      4'd1:    w_font = FONT_1;
      4'd2:    w_font = FONT_2;
      4'd3:    w_font = FONT_3;
      4'd4:    w_font = FONT_4;
      4'd5:    w_font = FONT_5;
      4'd6:    w_font = FONT_6;
      4'd7:    w_font = FONT_7;
      4'd8:    w_font = FONT_8;
      4'd9:    w_font = FONT_9;
      default: w_font = FONT_BLANK;
    endcase
    return w_font;
  endfunction

endpackage

// File: rtl/bin2bcd8.sv
// Sequential shift-add-3 (double-dabble) binary to BCD converter.
// A conversion starts whenever {i_sel,i_data} differs from the last value
// converted, or once unconditionally after reset. Inputs are only sampled
// in IDLE, so the newest value wins and intermediate values may be skipped.
//   i_clk, i_reset : clock, asynchronous active-high reset
//   i_data, i_sel  : value to convert and its operation select
//   o_bcd          : {hundreds, tens, ones}, valid while o_load is high
//   o_op           : operation select belonging to o_bcd
//   o_load         : one-cycle strobe, result ready to be captured
//   o_busy         : high while a conversion is in progress
module bin2bcd8
  import arith_fnd_pkg::*;
#(
  parameter int unsigned DATA_W = 8
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [DATA_W-1:0] i_data,
  input  logic [1:0]        i_sel,
  output logic [11:0]       o_bcd,
  output logic [1:0]        o_op,
  output logic              o_load,
  output logic              o_busy
);

  localparam int unsigned SH_W  = DATA_W + 12;
  localparam int unsigned CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  conv_state_t       r_state;
  logic [DATA_W+1:0] r_last;
  logic              r_force;
  logic [SH_W-1:0]   r_shift;
  logic [CNT_W-1:0]  r_cnt;

  logic [DATA_W+1:0] w_in;
  logic [SH_W-1:0]   w_adj;

  assign w_in = {i_sel, i_data};

  // Add-3 correction on each BCD nibble before the shift.
  always_comb begin
    w_adj = r_shift;
    for (int unsigned n = 0; n < 3; n++) begin
      if (r_shift[DATA_W + 4*n +: 4] >= 4'd5)
        w_adj[DATA_W + 4*n +: 4] = r_shift[DATA_W + 4*n +: 4] + 4'd3;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= IDLE;
      r_force <= 1'b1;
      r_last  <= '0;
      r_shift <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if ((w_in != r_last) || r_force) begin
            r_state <= CONV;
            r_last  <= w_in;
            r_shift <= {12'b0, i_data};
            r_cnt   <= '0;
            r_force <= 1'b0;
          end
        end
        CONV: begin
          r_shift <= {w_adj[SH_W-2:0], 1'b0};
          r_cnt   <= r_cnt + 1'b1;
          if (r_cnt == CNT_W'(DATA_W - 1))
            r_state <= LOAD;
        end
        LOAD: r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_bcd  = r_shift[SH_W-1:DATA_W];
  assign o_op   = r_last[DATA_W+1:DATA_W];
  assign o_load = (r_state == LOAD);
  assign o_busy = (r_state != IDLE);

endmodule

// File: rtl/arith_fnd_disp.sv
// Display stage for the 4-function arithmetic datapath: converts the 8-bit
// result to decimal and scans it, plus the operation code, onto four
// common-anode 7-segment digits.
//   i_clk, i_reset : clock, asynchronous active-high reset
//   i_data         : unsigned result
//   i_sel          : operation select that produced i_data
//   o_fnd_com      : digit enables, active-low (bit0 ones .. bit3 op)
//   o_fnd_font     : segments, active-low {dp,g,f,e,d,c,b,a}
//   o_busy         : conversion in progress
module arith_fnd_disp
  import arith_fnd_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 100_000,
  parameter int unsigned DATA_W   = 8
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [DATA_W-1:0] i_data,
  input  logic [1:0]        i_sel,
  output logic [3:0]        o_fnd_com,
  output logic [7:0]        o_fnd_font,
  output logic              o_busy
);

  localparam int unsigned PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [PRE_W-1:0] r_presc;
  logic [1:0]       r_idx;
  logic [11:0]      r_bcd;
  logic [1:0]       r_op;

  logic [11:0]      w_bcd;
  logic [1:0]       w_op;
  logic             w_load;

  bin2bcd8 #(
    .DATA_W(DATA_W)
  ) u_bin2bcd8 (
    .i_clk  (i_clk),
    .i_reset(i_reset),
    .i_data (i_data),
    .i_sel  (i_sel),
    .o_bcd  (w_bcd),
    .o_op   (w_op),
    .o_load (w_load),
    .o_busy (o_busy)
  );

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_bcd <= '0;
      r_op  <= '0;
    end else if (w_load) begin
      r_bcd <= w_bcd;
      r_op  <= w_op;
    end
  end

  // Free-running digit scanner, independent of the converter.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_presc <= '0;
      r_idx   <= '0;
    end else if (r_presc == PRE_W'(SCAN_DIV - 1)) begin
      r_presc <= '0;
      r_idx   <= r_idx + 1'b1;
    end else begin
      r_presc <= r_presc + 1'b1;
    end
  end

  // Leading zeros of tens/hundreds are blanked; the op digit has dp lit.
  always_comb begin
    o_fnd_com  = ~(4'b0001 << r_idx);
    o_fnd_font = FONT_BLANK;
    case (r_idx)
      2'd0: o_fnd_font = seg_font(r_bcd[3:0]);
      2'd1: o_fnd_font = ((r_bcd[11:8] == 4'd0) && (r_bcd[7:4] == 4'd0)) ?
                         FONT_BLANK : seg_font(r_bcd[7:4]);
      2'd2: o_fnd_font = (r_bcd[11:8] == 4'd0) ? FONT_BLANK : seg_font(r_bcd[11:8]);
      default: o_fnd_font = seg_font({2'b00, r_op}) & 8'h7F;
    endcase
  end

endmodule

// File: tb/tb_arith_fnd_disp.sv
// Scoreboard bench for arith_fnd_disp with a fast scan rate.
module tb_arith_fnd_disp;

  localparam int unsigned SD = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] data;
  logic [1:0] sel;
  logic [3:0] com;
  logic [7:0] font;
  logic       busy;

  int checks = 0;
  int errors = 0;

  logic [9:0]  sb[$];
  logic [9:0]  last_drv;
  int unsigned cyc;

  logic [7:0] font_ref [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

  always #5 clk = ~clk;

  arith_fnd_disp #(
    .SCAN_DIV(SD),
    .DATA_W  (8)
  ) dut (
    .i_clk     (clk),
    .i_reset   (rst),
    .i_data    (data),
    .i_sel     (sel),
    .o_fnd_com (com),
    .o_fnd_font(font),
    .o_busy    (busy)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Expected segments for digit position idx when value v = {sel,data} is displayed.
  function automatic logic [7:0] ref_font(input logic [9:0] v, input int unsigned idx);
    int unsigned n, h, t, o;
    n = int'(v[7:0]);
    h = n / 100;
    t = (n / 10) % 10;
    o = n % 10;
    case (idx)
      0: return font_ref[o];
      1: return (h == 0 && t == 0) ? 8'hFF : font_ref[t];
      2: return (h == 0) ? 8'hFF : font_ref[h];
      default: return font_ref[int'(v[9:8])] & 8'h7F;
    endcase
  endfunction

  // Edges seen since reset release; the active digit follows from it.
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  // Monitor: a falling o_busy presents a new result; the display is
  // checked against the current expected value every cycle.
  logic [9:0]  cur;
  int unsigned busy_len;
  logic        prev_busy;

  always @(negedge clk) begin
    int unsigned idx;
    logic [3:0]  exp_com;
    if (rst) begin
      chk("rst_com",  32'(com),  32'h0000000E);
      chk("rst_font", 32'(font), 32'h000000C0);
      chk("rst_busy", 32'(busy), 32'h0);
      cur       = '0;
      busy_len  = 0;
      prev_busy = 1'b0;
    end else begin
      if (busy) begin
        busy_len++;
      end else if (prev_busy) begin
        chk("busy_len", 32'(busy_len), 32'd9);
        busy_len = 0;
        chk("queue_has_entry", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) cur = sb.pop_front();
      end
      prev_busy = busy;
      idx = (cyc / SD) % 4;
      exp_com = 4'b1111;
      exp_com[idx] = 1'b0;
      chk("com", 32'(com), 32'(exp_com));
      chk("font", 32'(font), 32'(ref_font(cur, idx)));
    end
  end

  task automatic step(input int unsigned n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic drive(input logic [7:0] d, input logic [1:0] s, input bit expect_conv);
    data = d;
    sel  = s;
    if (expect_conv) sb.push_back({s, d});
    last_drv = {s, d};
  endtask

  // A change held long enough is always converted.
  task automatic drv(input logic [7:0] d, input logic [1:0] s);
    drive(d, s, ({s, d} != last_drv));
  endtask

  logic [7:0] rd;
  logic [1:0] rs;

  initial begin
    data     = '0;
    sel      = '0;
    last_drv = '0;
    #1 rst = 1'b1;
    step(4);
    sb.push_back(10'd0);
    rst = 1'b0;
    step(20);

    drv(8'd255, 2'b10); step(30);
    drv(8'd7,   2'b10); step(20);
    drv(8'd40,  2'b10); step(20);

    drv(8'd12, 2'b00); step(20);
    drv(8'd12, 2'b11); step(20);

    // 9 arrives mid-conversion and is superseded by 200 before sampling
    drive(8'd100, 2'b00, 1'b1); step(3);
    drive(8'd9,   2'b00, 1'b0); step(2);
    drive(8'd200, 2'b00, 1'b1); step(30);

    // reset in the middle of a conversion, then a forced reconversion
    drive(8'd199, 2'b01, 1'b1); step(4);
    rst = 1'b1;
    step(3);
    sb.delete();
    sb.push_back({2'b01, 8'd199});
    rst = 1'b0;
    step(30);

    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 5))
        0: rd = 8'd0;
        1: rd = 8'd255;
        2: rd = 8'd99;
        3: rd = 8'd100;
        default: rd = 8'($urandom_range(0, 255));
      endcase
      rs = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 4) == 0) rd = last_drv[7:0];
      drv(rd, rs);
      step($urandom_range(12, 25));
    end
    step(30);

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/arith_fnd_disp.md
# arith_fnd_disp

Downstream display stage of the 4-function arithmetic datapath. It takes the selected 8-bit result and the 2-bit operation select from the result multiplexer. It converts the result to three BCD digits with a sequential shift-add-3 (double-dabble) engine. It time-multiplexes four common-anode 7-segment digits: ones, tens and hundreds of the result, plus the operation code.

## Interface
Parameters:
- `SCAN_DIV`, 100_000: clock cycles each digit stays lit. Legal range is ≥1.
- `DATA_W`, 8: result width. Fixed at 8; the conversion length is DATA_W cycles.

Ports:
- `i_clk`  in  1  single system clock, rising edge.
- `i_reset`  in  1  asynchronous, active-high reset.
- `i_data`  in  8  unsigned result from the multiplexer.
- `i_sel`  in  2  operation select that produced `i_data`.
- `o_fnd_com`  out  4  digit enables, active-low. Bit 0 is the ones digit; bit 3 is the op digit.
- `o_fnd_font`  out  8  segments, active-low, ordered {dp,g,f,e,d,c,b,a}.
- `o_busy`  out  1  high while a conversion is in progress.

## Operation
- Converter FSM has three states: IDLE, CONV, LOAD.
- **IDLE**
  - Transition to CONV when {i_sel,i_data} ≠ r_last, or when r_force=1.
  - On that transition: r_last ← {i_sel,i_data}; shift reg ← {12'b0, i_data}; cnt ← 0; r_force ← 0.
- **CONV**, once per cycle:
  - Each of the three BCD nibbles that is ≥5 gets +3.
  - Then the 20-bit shift reg shifts left by 1 and cnt increments.
  - After the 8th shift (cnt==7 on entry), go to LOAD.
- **LOAD**
  - Display regs ← {hundreds, tens, ones}; r_op ← r_last[9:8].
  - Go to IDLE.
- Input changes during CONV/LOAD are not sampled. They are compared on return to IDLE; the latest value always wins, and intermediate values may be skipped.
- `o_busy` = (state ≠ IDLE).
- **Scanner**
  - Prescaler counts 0..SCAN_DIV-1 continuously.
  - At the terminal count, the prescaler resets and digit index idx = (idx+1) mod 4.
  - Scanning is independent of the converter and never stalls.
- **Output decode**, combinational from registers only:
  - o_fnd_com = ~(4'b0001 << idx).
  - idx 0: font(ones).
  - idx 1: font(tens), blanked (8'hFF) when hundreds==0 and tens==0.
  - idx 2: font(hundreds), blanked when hundreds==0.
  - idx 3: font(r_op) with dp lit (bit 7 cleared).
- **Font table**: 0:C0, 1:F9, 2:A4, 3:B0, 4:99, 5:92, 6:82, 7:F8, 8:80, 9:90, blank:FF.

## Timing
- **Reset** (asynchronous assert, synchronous deassert handled upstream):
  - state=IDLE, r_force=1, r_last=0, BCD regs=0, r_op=0, idx=0, prescaler=0.
  - Outputs during reset: o_fnd_com=4'b1110, o_fnd_font=8'hC0, o_busy=0.
- **Latency**:
  - Change is seen in IDLE at edge k.
  - o_busy rises after edge k; CONV spans edges k+1..k+8.
  - LOAD at edge k+9 updates the display regs. o_busy falls and new segments appear after edge k+9: 9 cycles in total.
- **First conversion** begins at the first edge after reset release, because r_force=1.
- **Back-to-back changes**: a new value present at the IDLE edge after LOAD starts the next conversion immediately. Minimum conversion period is 10 cycles.
- **Reset mid-CONV**: the conversion is aborted, all registers return to reset values, and the display shows 0.
- **SCAN_DIV=1**: idx advances every cycle.
- **Prescaler width**: $clog2(SCAN_DIV), minimum 1 bit.

## Structure
- Package `arith_fnd_pkg` holds:
  - the state enum {IDLE, CONV, LOAD};
  - the font constants FONT_0..FONT_9 and FONT_BLANK;
  - the function `seg_font(input [3:0])`.
- Sub-module `bin2bcd8` contains the FSM, shift register, r_last, r_force and o_busy. It outputs 12-bit BCD with a one-cycle `o_load` strobe.
- The top level holds the display regs, r_op, prescaler, scanner and output decode.

## Test plan
- **Reset**: hold i_reset with SCAN_DIV=4 → o_fnd_com=1110, o_fnd_font=C0, o_busy=0. After release with i_data=0 and i_sel=0, o_busy is high for exactly 9 cycles, and the display still shows "0".
- **Value 8'd255, i_sel=2'b10**: o_busy is high for 9 cycles. The scan then shows ones=92 ("5"), tens=92 ("5"), hundreds=A4 ("2"), and the op digit with com 0111 shows font 24.
- **Leading-zero blanking**: i_data=8'd7 → ones F9? no: ones=F8 ("7"); tens and hundreds both FF. Then i_data=8'd40 → ones=C0, tens=99, hundreds=FF.
- **Change during CONV**: 8'd100 at edge k, 8'd9 at k+3, 8'd200 at k+5 held. The display shows 100 after k+9. The next conversion starts at k+10 and the display shows 200 after k+19; 9 never appears.
- **Sel-only change**: i_data stays at 8'd12 while i_sel goes 00→11. A conversion runs, and the op digit changes from 40 to 30 after 9 cycles with ones=A4 and tens=F9 unchanged.
- **Reset mid-CONV**: assert i_reset at k+4 while 8'd199 is converting → immediate reset values. After release, a fresh conversion runs, and the display shows 199 nine cycles after it starts.
